// File: rtl/encoder_pkg.sv
// Shared FSM state type, drop-counter width and saturating increment for encoder_queue.
package encoder_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational wrap-around search: returns the first set bit of i_vec starting at i_start,
// walking upward (DESCEND=0) or downward (DESCEND=1).
module prio_pick #(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = $clog2(N),
  parameter bit          DESCEND = 1'b0
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic         o_found_c,
  output logic [W-1:0] o_idx_c
);

  logic [W-1:0] w_pos;

  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    o_found_c = 1'b0;
    o_idx_c   = '0;
    w_pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (DESCEND) begin
        w_pos = W'((32'(i_start) + N - 32'(k)) % N);
      end else begin
        w_pos = W'((32'(i_start) + 32'(k)) % N);
      end
      if (i_vec[w_pos]) begin
        o_found_c = 1'b1;
        o_idx_c   = w_pos;
      end
    end
  end

endmodule

// File: rtl/encoder_queue.sv
// Collects request lines into a pending set and presents one encoded index at a time.
// Define ENCODER_QUEUE_RR_EN for round-robin selection; otherwise highest index wins.
module encoder_queue
  import encoder_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_idx,
  output logic [N-1:0]          pending,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_out_valid;
  logic                    w_out_valid_nxt;
  logic [W-1:0]            r_out_idx;
  logic [W-1:0]            w_out_idx_nxt;
  logic [N-1:0]            r_pending;
  logic [N-1:0]            w_pending_nxt;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [DROP_CNT_W-1:0]   w_drop_cnt_nxt;

  logic                    w_hs;
  logic [N-1:0]            w_hs_vec;
  logic                    w_drop_hit;
  logic                    w_found;
  logic [W-1:0]            w_sel_idx;
  logic [W-1:0]            w_start;

  // A flush cancels any handshake offered in the same cycle.
  assign w_hs       = (r_state == PRESENT) && out_ready && !clr;
  assign w_hs_vec   = w_hs ? (N'(1) << r_out_idx) : '0;
  assign w_drop_hit = |(req & r_pending & ~w_hs_vec);

`ifdef ENCODER_QUEUE_RR_EN
  logic [W-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= W'(N - 1);
    end else if (w_hs) begin
      r_last <= r_out_idx;
    end
  end

  assign w_start = (r_last == W'(N - 1)) ? '0 : r_last + W'(1);

  prio_pick #(.N(N), .W(W), .DESCEND(1'b0)) u_pick (
    .i_vec     (r_pending),
    .i_start   (w_start),
    .o_found_c (w_found),
    .o_idx_c   (w_sel_idx)
  );
`else
  assign w_start = W'(N - 1);

  prio_pick #(.N(N), .W(W), .DESCEND(1'b1)) u_pick (
    .i_vec     (r_pending),
    .i_start   (w_start),
    .o_found_c (w_found),
    .o_idx_c   (w_sel_idx)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_pending   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_idx   <= w_out_idx_nxt;
      r_pending   <= w_pending_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
    end
  end

  // Next state and presented output.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_valid_nxt = r_out_valid;
    w_out_idx_nxt   = r_out_idx;
    if (clr) begin
      w_state_nxt     = IDLE;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_state_nxt     = PRESENT;
            w_out_valid_nxt = 1'b1;
            w_out_idx_nxt   = w_sel_idx;
          end else begin
            w_out_valid_nxt = 1'b0;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            w_state_nxt     = IDLE;
            w_out_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt     = IDLE;
          w_out_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Pending set (new requests win over a same-cycle handshake) and drop counter.
  always_comb begin
    w_pending_nxt  = (r_pending & ~w_hs_vec) | req;
    w_drop_cnt_nxt = r_drop_cnt;
    if (clr) begin
      w_pending_nxt = '0;
    end
    if (w_drop_hit) begin
      w_drop_cnt_nxt = sat_inc(r_drop_cnt);
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign pending   = r_pending;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_encoder_queue.sv
// Scoreboard bench for encoder_queue: expected indices are queued at stimulus time and
// popped by a handshake monitor; state checks cover reset, stalls, drops, flush and abort.
module tb_encoder_queue;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [N-1:0] req = '0;
  logic [N-1:0] pending;
  logic [W-1:0] out_idx;
  logic [7:0]   drop_cnt;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  int unsigned  exp_q[$];

  always #5 clk = ~clk;

  encoder_queue #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input string tag);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      step(1);
      k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // A handshake completes at the next rising edge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !clr) begin
      if (exp_q.size() == 0) check("unexpected_hs", 32'(out_idx), 32'hFFFF_FFFF);
      else                   check("hs_idx", 32'(out_idx), exp_q.pop_front());
    end
  end

  initial begin
    #2;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_idx",     32'(out_idx),   32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_drop",    32'(drop_cnt),  32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Two simultaneous requests, one-cycle pulse, consumer always ready.
    out_ready = 1'b1;
    req = 8'h44;
`ifdef ENCODER_QUEUE_RR_EN
    exp_q.push_back(2); exp_q.push_back(6);
`else
    exp_q.push_back(6); exp_q.push_back(2);
`endif
    step(1);
    req = '0;
    check("lat_pending", 32'(pending),   32'h44);
    check("lat_valid0",  32'(out_valid), 32'd0);
    step(1);
    check("lat_valid1",  32'(out_valid), 32'd1);
`ifdef ENCODER_QUEUE_RR_EN
    check("lat_idx",     32'(out_idx),   32'd2);
`else
    check("lat_idx",     32'(out_idx),   32'd6);
`endif
    wait_empty("pair_drain");
    check("pair_pending", 32'(pending), 32'd0);

    // Stalled presentation of index 3 while request 7 arrives.
    out_ready = 1'b0;
    req = 8'h08;
    exp_q.push_back(3);
    step(1);
    req = '0;
    step(1);
    req = 8'h80;
    exp_q.push_back(7);
    step(1);
    req = '0;
    for (int i = 0; i < 5; i++) begin
      check("stall_idx",   32'(out_idx),   32'd3);
      check("stall_valid", 32'(out_valid), 32'd1);
      step(1);
    end
    check("stall_pending", 32'(pending), 32'h88);
    out_ready = 1'b1;
    wait_empty("stall_drain");
    check("stall_pending_end", 32'(pending), 32'd0);

    // Held request counts drops; long hold saturates the counter.
    out_ready = 1'b0;
    req = 8'h20;
    exp_q.push_back(5);
    step(4);
    req = '0;
    check("drop_3", 32'(drop_cnt), 32'd3);
    out_ready = 1'b1;
    wait_empty("drop_drain");
    out_ready = 1'b0;
    req = 8'h01;
    exp_q.push_back(0);
    step(100);
    check("drop_102", 32'(drop_cnt), 32'd102);
    step(200);
    check("drop_sat", 32'(drop_cnt), 32'd255);
    req = '0;
    out_ready = 1'b1;
    wait_empty("sat_drain");

`ifndef ENCODER_QUEUE_RR_EN
    // Fixed priority ordering across four requests.
    req = 8'hA5;
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    step(1);
    req = '0;
    wait_empty("prio_drain");
    check("prio_pending", 32'(pending), 32'd0);
`endif

    // Flush during presentation beats a simultaneous handshake and discards new requests.
    out_ready = 1'b0;
    req = 8'h10;
    step(1);
    req = '0;
    step(1);
    check("clr_pre_valid", 32'(out_valid), 32'd1);
    check("clr_pre_idx",   32'(out_idx),   32'd4);
    clr = 1'b1;
    out_ready = 1'b1;
    req = 8'h01;
    step(1);
    clr = 1'b0;
    req = '0;
    check("clr_valid",   32'(out_valid), 32'd0);
    check("clr_pending", 32'(pending),   32'd0);
    check("clr_drop",    32'(drop_cnt),  32'd255);
    step(2);
    check("clr_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a presentation.
    out_ready = 1'b0;
    req = 8'h02;
    step(1);
    req = '0;
    step(1);
    check("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",   32'(out_valid), 32'd0);
    check("arst_pending", 32'(pending),   32'd0);
    check("arst_drop",    32'(drop_cnt),  32'd0);
    req = 8'h04;
    step(2);
    req = '0;
    rst_n = 1'b1;
    step(1);
    check("arst_no_capture", 32'(pending),   32'd0);
    check("arst_idle",       32'(out_valid), 32'd0);

`ifdef ENCODER_QUEUE_RR_EN
    // Round-robin rotation with every line held high.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    out_ready = 1'b1;
    req = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    wait_empty("rr_drain");
    req = '0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("rr_flush_pending", 32'(pending), 32'd0);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/encoder_queue.md
ENCODER_QUEUE -- requirements
Module: encoder_queue

Interface
REQ-001 Parameter N, default 8, number of request lines; legal range 2..32.
REQ-002 Parameter W, default $clog2(N), output index width; derived, never overridden.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N  request lines; bit i high for one or more cycles posts a request for index i.
REQ-006 clr  input  1  synchronous flush of pending requests and output.
REQ-007 out_valid  output  1  out_idx holds an encoded request.
REQ-008 out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
REQ-009 out_idx  output  W  binary index of the presented request.
REQ-010 pending  output  N  registered request bits not yet served.
REQ-011 drop_cnt  output  8  saturating count of cycles in which a request hit an already-pending bit.

Function
REQ-012 Each cycle, pending[i] SHALL be set by req[i] and cleared only when index i completes a handshake or clr is high.
REQ-013 If req[i] is high in the same cycle index i completes a handshake, pending[i] SHALL remain set (set wins).
REQ-014 FSM SHALL have two states, IDLE and PRESENT.
REQ-015 IDLE: if pending is nonzero, the block SHALL register the selected index into out_idx, assert out_valid, and move to PRESENT; otherwise it SHALL stay in IDLE with out_valid low.
REQ-016 PRESENT: out_idx and out_valid SHALL be held stable while out_ready is low.
REQ-017 PRESENT with out_ready high: the block SHALL clear pending[out_idx], deassert out_valid, and return to IDLE at the same edge.
REQ-018 Latency: a req pulse at edge k into an empty, idle block SHALL produce out_valid at edge k+1; the sustained throughput SHALL be one index per two cycles.
REQ-019 Default selection SHALL be fixed priority: the highest set index of pending wins.
REQ-020 Requests arriving while PRESENT SHALL only update pending and SHALL NOT change out_idx.
REQ-021 drop_cnt SHALL increment by exactly 1 in any cycle where at least one bit i has req[i] && pending[i] and i is not being handshaken; it SHALL saturate at 255.
REQ-022 clr SHALL zero pending, deassert out_valid, and force IDLE at the next edge; req in the clr cycle SHALL be discarded; drop_cnt SHALL be unaffected.
REQ-023 clr SHALL take priority over a simultaneous handshake.

Reset
REQ-024 rst_n low SHALL immediately force FSM=IDLE, out_valid=0, out_idx=0, pending=0, drop_cnt=0, and the round-robin pointer=N-1.
REQ-025 Reset asserted mid-presentation SHALL abort the output with no handshake counted.
REQ-026 Deassertion SHALL be honoured at the next clk edge; no request is captured during reset.

Configuration
REQ-027 With macro ENCODER_QUEUE_RR_EN defined, selection SHALL be round-robin: the search starts at last_granted+1 upward with wraparound to 0, and last_granted updates on each handshake.
REQ-028 Without ENCODER_QUEUE_RR_EN, the pointer logic SHALL be absent and REQ-019 SHALL apply.

Structure
REQ-029 Package encoder_pkg SHALL hold the FSM state typedef (IDLE, PRESENT) and the constant DROP_CNT_W=8.
REQ-030 Sub-module prio_pick SHALL be purely combinational (N-bit vector plus start index in, found flag plus W-bit index out) and be used for both selection modes.

Verification
REQ-031 N=8, fixed priority: req=8'b0100_0100 for 1 cycle, out_ready=1 -> out_idx=6 then out_idx=2 on successive presentations, pending=0 afterwards.
REQ-032 out_ready=0 for 5 cycles with out_idx=3 while req[7] pulses -> out_idx stays 3 and pending[7]=1; after the handshake, the next out_idx=7.
REQ-033 req[5] held high for 4 cycles before being served -> drop_cnt=3; forcing 300 drop cycles -> drop_cnt=255.
REQ-034 With ENCODER_QUEUE_RR_EN, req=8'hFF held continuously, out_ready=1 -> out_idx sequence 0,1,...,7,0.
REQ-035 clr during PRESENT with a simultaneous handshake and req=8'h01 -> next cycle out_valid=0 and pending=0.
REQ-036 rst_n low mid-PRESENT -> out_valid=0, pending=0, and drop_cnt=0 asynchronously, before the next clk edge.
